// File: rtl/bus_mem_slave.sv
// Word-addressed RAM target for one crossbar slave port: one transaction at a time over
// req/ack/cmd/resp, with a programmable access latency and a post-response turnaround gap.
module bus_mem_slave #(
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2,
    parameter int TURNAROUND = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        cmd,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        resp,
    output logic [31:0] rdata,
    output logic [2:0]  o_dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);

    // Handshake: req is a level from the crossbar; ack pulses for exactly one cycle and
    // addr/cmd/wdata are only meaningful during it; resp pulses once per accepted request.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACK  = 3'd1,
        S_WAIT = 3'd2,
        S_RESP = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_next;
    logic               r_cmd;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_wdata;
    logic [31:0]        r_mem [DEPTH];
    logic               w_mem_we;
    logic               w_unused_addr;

    // Only the word-index bits select a location; the rest belong to crossbar decode.
    assign w_unused_addr = &{1'b0, addr[31:IDX_W+2], addr[1:0]};

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req) w_next = S_ACK;
            end
            S_ACK: begin
                w_next     = S_WAIT;
                w_cnt_next = 4'(LATENCY - 1);
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) w_next = S_RESP;
                else               w_cnt_next = r_cnt - 4'd1;
            end
            S_RESP: begin
                w_next     = S_GAP;
                w_cnt_next = 4'(TURNAROUND - 1);
            end
            S_GAP: begin
                if (r_cnt == 4'd0) w_next = S_IDLE;
                else               w_cnt_next = r_cnt - 4'd1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_cmd   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            ack     <= 1'b0;
            resp    <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            ack     <= (w_next == S_ACK);
            resp    <= (w_next == S_RESP);
            if (r_state == S_ACK) begin
                r_cmd   <= cmd;
                r_idx   <= addr[2 +: IDX_W];
                r_wdata <= wdata;
            end
            if (w_next == S_RESP && !r_cmd) rdata <= r_mem[r_idx];
            else                            rdata <= 32'd0;
        end
    end

    // The write is captured at ACK but committed on the edge that enters RESP, so a
    // transaction cut short by reset never disturbs memory.
    assign w_mem_we = (r_state == S_WAIT) && (r_cnt == 4'd0) && r_cmd;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_idx] <= r_wdata;
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Bench for bus_mem_slave: three instances (latency 2/1/15) checked against an array memory
// model and cycle arithmetic derived from the latency/turnaround rules.
module tb_bus_mem_slave;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_v;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ack_v;
    logic [2:0]  resp_v;
    logic [31:0] rdata_v [3];
    logic [2:0]  st_v [3];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] model_mem [3][DEPTH];
    bit          model_ok  [3][DEPTH];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_mem_slave #(.DEPTH(DEPTH), .LATENCY(2), .TURNAROUND(2)) u_dut (
        .clk(clk), .reset(reset), .req(req_v[0]), .cmd(cmd), .addr(addr), .wdata(wdata),
        .ack(ack_v[0]), .resp(resp_v[0]), .rdata(rdata_v[0]), .o_dbg_state(st_v[0]));
    bus_mem_slave #(.DEPTH(DEPTH), .LATENCY(1), .TURNAROUND(1)) u_lat1 (
        .clk(clk), .reset(reset), .req(req_v[1]), .cmd(cmd), .addr(addr), .wdata(wdata),
        .ack(ack_v[1]), .resp(resp_v[1]), .rdata(rdata_v[1]), .o_dbg_state(st_v[1]));
    bus_mem_slave #(.DEPTH(DEPTH), .LATENCY(15), .TURNAROUND(3)) u_lat15 (
        .clk(clk), .reset(reset), .req(req_v[2]), .cmd(cmd), .addr(addr), .wdata(wdata),
        .ack(ack_v[2]), .resp(resp_v[2]), .rdata(rdata_v[2]), .o_dbg_state(st_v[2]));

    function automatic int lat_f(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 1 : 15);
    endfunction

    function automatic int ta_f(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 1 : 3);
    endfunction

    function automatic int idx_f(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ack and resp must never overlap on any instance
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int s = 0; s < 3; s++) begin
                n_cmp++;
                assert (!(ack_v[s] && resp_v[s])) else begin
                    n_fail++;
                    $error("FAIL ack_resp_overlap[%0d]: observed 1 expected 0", s);
                end
            end
        end
    end

    // One complete transaction; entered and left just after a rising edge with the DUT idle.
    task automatic txn(input int s, input logic c, input logic [31:0] a, input logic [31:0] d,
                       input bit early_drop, input string tag);
        int n, lat, ta, idx, acks, r_cyc;
        bit seen;
        logic [31:0] exp;
        lat = lat_f(s);
        ta  = ta_f(s);
        idx = idx_f(a);
        if (c) begin
            model_mem[s][idx] = d;
            model_ok[s][idx]  = 1'b1;
            exp_q.push_back(32'd0);
        end else begin
            exp_q.push_back(model_mem[s][idx]);
        end
        cmd = c; addr = a; wdata = d; req_v[s] = 1'b1;
        n = cyc + 1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (ack_v[s]) seen = 1'b1;
        end
        check({tag, " ack_seen"}, 32'(seen), 32'd1);
        check({tag, " ack_cycle"}, 32'(cyc), 32'(n));
        @(posedge clk); #1;
        if (early_drop) req_v[s] = 1'b0;
        cmd = 1'($urandom); addr = $urandom; wdata = $urandom;
        seen = 1'b0; acks = 0; r_cyc = -1;
        for (int k = 0; k < lat + 4 && !seen; k++) begin
            @(negedge clk);
            if (ack_v[s]) acks++;
            if (resp_v[s]) begin
                seen  = 1'b1;
                r_cyc = cyc;
            end
        end
        exp = exp_q.pop_front();
        check({tag, " resp_seen"}, 32'(seen), 32'd1);
        check({tag, " extra_ack"}, 32'(acks), 32'd0);
        check({tag, " resp_cycle"}, 32'(r_cyc), 32'(n + 1 + lat));
        check({tag, " rdata"}, rdata_v[s], exp);
        @(posedge clk); #1;
        req_v[s] = 1'b0;
        acks = 0;
        for (int k = 0; k < ta + 1; k++) begin
            @(negedge clk);
            if (ack_v[s] || resp_v[s]) acks++;
            if (rdata_v[s] !== 32'd0) acks++;
        end
        check({tag, " quiet_after_resp"}, 32'(acks), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int acks, resps, n0, idx, seen;
        int a_q [$];
        int r_q [$];
        logic c;
        logic [31:0] a, d;

        reset = 1'b0; req_v = 3'b000; cmd = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset_ack[%0d]", s), 32'(ack_v[s]), 32'd0);
            check($sformatf("reset_resp[%0d]", s), 32'(resp_v[s]), 32'd0);
            check($sformatf("reset_rdata[%0d]", s), rdata_v[s], 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // write then read back at the same byte address
        txn(0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, "t2_wr");
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, "t2_rd");
        check("t2_const", model_mem[0][4], 32'h1234_5678);

        // reset in the middle of a write's wait phase must leave word 5 untouched
        txn(0, 1'b1, 32'h0000_0014, 32'hCAFE_0000, 1'b0, "t1_pre");
        cmd = 1'b1; addr = 32'h0000_0014; wdata = 32'hDEAD_BEEF; req_v[0] = 1'b1;
        seen = 0;
        for (int k = 0; k < 8 && seen == 0; k++) begin
            @(negedge clk);
            if (ack_v[0]) seen = 1;
        end
        check("t1_ack_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t1_ack_now", 32'(ack_v[0]), 32'd0);
        check("t1_resp_now", 32'(resp_v[0]), 32'd0);
        check("t1_rdata_now", rdata_v[0], 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        resps = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_v[0]) resps++;
        end
        check("t1_no_resp_after_abort", 32'(resps), 32'd0);
        @(posedge clk); #1;
        txn(0, 1'b0, 32'h0000_0014, 32'h0, 1'b0, "t1_word5");

        // reset asserted while resp is high clears resp/rdata asynchronously
        cmd = 1'b0; addr = 32'h0000_0010; req_v[0] = 1'b1;
        seen = 0;
        for (int k = 0; k < 12 && seen == 0; k++) begin
            @(negedge clk);
            if (resp_v[0]) seen = 1;
        end
        check("t1b_resp_seen", 32'(seen), 32'd1);
        check("t1b_rdata", rdata_v[0], model_mem[0][4]);
        req_v[0] = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("t1b_resp_cleared", 32'(resp_v[0]), 32'd0);
        check("t1b_rdata_cleared", rdata_v[0], 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // latency extremes
        txn(1, 1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0, "t3_l1_wr");
        txn(1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, "t3_l1_rd");
        txn(2, 1'b1, 32'h0000_0024, 32'h3333_4444, 1'b0, "t3_l15_wr");
        txn(2, 1'b0, 32'h0000_0024, 32'h0, 1'b0, "t3_l15_rd");
        txn(2, 1'b0, 32'h0000_0024, 32'h0, 1'b1, "t3_l15_drop");

        // wrap / decode: upper and crossbar-decode bits ignored
        txn(0, 1'b1, 32'h8000_0400, 32'hA5A5_A5A5, 1'b0, "t4_wr");
        txn(0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, "t4_rd");
        check("t4_const", model_mem[0][0], 32'hA5A5_A5A5);

        // early drop of req on a read
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, "t6_drop");
        txn(0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, "t6_after");

        // req held high across four back-to-back reads
        cmd = 1'b0; addr = 32'h0000_0010; req_v[0] = 1'b1;
        n0 = cyc + 1; acks = 0; resps = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (ack_v[0]) begin
                acks++;
                a_q.push_back(cyc);
                if (acks == 4) req_v[0] = 1'b0;
            end
            if (resp_v[0]) begin
                resps++;
                r_q.push_back(cyc);
                check($sformatf("t5_rdata%0d", resps), rdata_v[0], model_mem[0][4]);
            end
            if (resps >= 4) break;
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack_v[0]) acks++;
            if (resp_v[0]) resps++;
        end
        check("t5_ack_count", 32'(acks), 32'd4);
        check("t5_resp_count", 32'(resps), 32'd4);
        if (a_q.size() == 4 && r_q.size() == 4) begin
            check("t5_first_ack", 32'(a_q[0]), 32'(n0));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t5_resp_lat%0d", i), 32'(r_q[i] - a_q[i]), 32'(2 + 1));
                if (i > 0)
                    check($sformatf("t5_spacing%0d", i), 32'(a_q[i] - a_q[i-1]), 32'(3 + 2 + 2));
            end
        end
        @(posedge clk); #1;

        // randomized traffic against the array model
        for (int t = 0; t < 24; t++) begin
            c = 1'($urandom_range(0, 1));
            a = $urandom;
            d = $urandom;
            idx = idx_f(a);
            if (!c && !model_ok[0][idx]) c = 1'b1;
            txn(0, c, a, d, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
